// File: rtl/csr_regfile_ex.sv
// csr_regfile_ex: machine-mode CSR file for the EX stage.
// Executes the six Zicsr ops against in-block CSR state, handles trap entry
// and mret with a one-cycle PC redirect, and runs a 64-bit cycle counter.
// Results are registered and returned through a valid/ready handshake.
module csr_regfile_ex #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0,
   parameter logic [XLEN-1:0] HART_ID     = '0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_rs1,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rd_data,
   output logic            out_illegal,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_val,
   input  logic            mret_valid,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            mstatus_mie
);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MCYCLEH  = 12'hB80;
   localparam logic [11:0] A_MHARTID  = 12'hF14;

   // Architectural CSR state
   logic            r_mie;
   logic            r_mpie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_mtval;
   logic [63:0]     r_mcycle;

   // Result stage and redirect registers
   logic            r_vld_p1;
   logic [XLEN-1:0] r_rd_data_p1;
   logic            r_illegal_p1;
   logic            r_redirect_valid;
   logic [XLEN-1:0] r_redirect_pc;

   // Decode / execute wires
   logic [2:0]      w_funct3;
   logic [4:0]      w_zimm;
   logic [11:0]     w_addr;
   logic [XLEN-1:0] w_src;
   logic [XLEN-1:0] w_old;
   logic [XLEN-1:0] w_new;
   logic            w_mapped;
   logic            w_wr_req;
   logic            w_illegal;
   logic            w_in_ready;
   logic            w_accept;
   logic            w_csr_we;
   logic            w_we_mstatus;
   logic            w_we_mtvec;
   logic            w_we_mscratch;
   logic            w_we_mepc;
   logic            w_we_mcause;
   logic            w_we_mtval;
   logic            w_we_mcycle;
   logic            w_we_mcycleh;
   logic            w_unused_inst;

   // mstatus as seen by software: MIE, MPIE live, MPP hardwired to M-mode.
   function automatic logic [XLEN-1:0] f_mstatus_rd(input logic mie, input logic mpie);
      logic [XLEN-1:0] v;
      v        = '0;
      v[3]     = mie;
      v[7]     = mpie;
      v[12:11] = 2'b11;
      return v;
   endfunction

   // mtvec keeps the mode bit and base; bit 1 is reserved and reads zero.
   function automatic logic [XLEN-1:0] f_mtvec_legal(input logic [XLEN-1:0] v);
      return {v[XLEN-1:2], 1'b0, v[0]};
   endfunction

   // Trap target: direct mode goes to the base, vectored interrupts are
   // offset by four bytes per cause number.
   function automatic logic [XLEN-1:0] f_trap_target(input logic [XLEN-1:0] tvec,
                                                     input logic [XLEN-1:0] cause);
      logic [XLEN-1:0] base;
      base = {tvec[XLEN-1:2], 2'b00};
      if (tvec[0] && cause[XLEN-1]) begin
         return base + {cause[XLEN-3:0], 2'b00};
      end
      return base;
   endfunction

   assign w_funct3      = in_inst[14:12];
   assign w_zimm        = in_inst[19:15];
   assign w_addr        = in_inst[31:20];
   assign w_unused_inst = ^in_inst[11:0];

   // Source operand: GPR for register forms, zero-extended zimm for immediate forms.
   assign w_src = w_funct3[2] ? {{(XLEN-5){1'b0}}, w_zimm} : in_rs1;

   // Set/clear with a zero rs1/zimm field are pure reads.
   assign w_wr_req = (w_funct3[1:0] == 2'b01) || (w_zimm != 5'd0);

   // CSR read mux and address map.
   always_comb begin
      w_mapped = 1'b1;
      w_old    = '0;
      case (w_addr)
         A_MSTATUS:  w_old = f_mstatus_rd(r_mie, r_mpie);
         A_MTVEC:    w_old = r_mtvec;
         A_MSCRATCH: w_old = r_mscratch;
         A_MEPC:     w_old = r_mepc;
         A_MCAUSE:   w_old = r_mcause;
         A_MTVAL:    w_old = r_mtval;
         A_MCYCLE:   w_old = r_mcycle[XLEN-1:0];
         A_MCYCLEH: begin
            if (XLEN == 32) begin
               w_old = XLEN'(r_mcycle[63:32]);
            end else begin
               w_mapped = 1'b0;
            end
         end
         A_MHARTID:  w_old = HART_ID;
         default:    w_mapped = 1'b0;
      endcase
   end

   // Op execution: write, set or clear against the old value.
   always_comb begin
      w_new = w_old;
      case (w_funct3[1:0])
         2'b01:   w_new = w_src;
         2'b10:   w_new = w_old | w_src;
         2'b11:   w_new = w_old & ~w_src;
         default: w_new = w_old;
      endcase
   end

   assign w_illegal = !w_mapped
                    || (w_funct3[1:0] == 2'b00)
                    || (w_wr_req && (w_addr[11:10] == 2'b11));

   // Traps and mret own the cycle; a CSR op is held off until they are gone.
   assign w_in_ready = (!r_vld_p1 || out_ready) && !trap_valid && !mret_valid;
   assign w_accept   = in_valid && w_in_ready;
   assign w_csr_we   = w_accept && !w_illegal && w_wr_req;

   assign w_we_mstatus  = w_csr_we && (w_addr == A_MSTATUS);
   assign w_we_mtvec    = w_csr_we && (w_addr == A_MTVEC);
   assign w_we_mscratch = w_csr_we && (w_addr == A_MSCRATCH);
   assign w_we_mepc     = w_csr_we && (w_addr == A_MEPC);
   assign w_we_mcause   = w_csr_we && (w_addr == A_MCAUSE);
   assign w_we_mtval    = w_csr_we && (w_addr == A_MTVAL);
   assign w_we_mcycle   = w_csr_we && (w_addr == A_MCYCLE);
   assign w_we_mcycleh  = w_csr_we && (w_addr == A_MCYCLEH);

   // Result holding register: loads on accept, drains when downstream takes it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_vld_p1     <= 1'b0;
         r_rd_data_p1 <= '0;
         r_illegal_p1 <= 1'b0;
      end else if (w_accept) begin
         r_vld_p1     <= 1'b1;
         r_rd_data_p1 <= w_illegal ? '0 : w_old;
         r_illegal_p1 <= w_illegal;
      end else if (out_ready) begin
         r_vld_p1     <= 1'b0;
      end
   end

   // mstatus interrupt-enable stack: trap pushes, mret pops, CSR ops write.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mie  <= 1'b0;
         r_mpie <= 1'b0;
      end else if (trap_valid) begin
         r_mpie <= r_mie;
         r_mie  <= 1'b0;
      end else if (mret_valid) begin
         r_mie  <= r_mpie;
         r_mpie <= 1'b1;
      end else if (w_we_mstatus) begin
         r_mie  <= w_new[3];
         r_mpie <= w_new[7];
      end
   end

   // Software-only CSRs: mtvec and mscratch.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mtvec    <= f_mtvec_legal(MTVEC_RESET);
         r_mscratch <= '0;
      end else begin
         if (w_we_mtvec) begin
            r_mtvec <= f_mtvec_legal(w_new);
         end
         if (w_we_mscratch) begin
            r_mscratch <= w_new;
         end
      end
   end

   // Trap record CSRs: loaded by trap entry, otherwise writable by software.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mepc   <= '0;
         r_mcause <= '0;
         r_mtval  <= '0;
      end else if (trap_valid) begin
         r_mepc   <= {trap_pc[XLEN-1:2], 2'b00};
         r_mcause <= trap_cause;
         r_mtval  <= trap_val;
      end else begin
         if (w_we_mepc) begin
            r_mepc <= {w_new[XLEN-1:2], 2'b00};
         end
         if (w_we_mcause) begin
            r_mcause <= w_new;
         end
         if (w_we_mtval) begin
            r_mtval <= w_new;
         end
      end
   end

   // Free-running cycle counter; a software write replaces a half and skips the tick.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mcycle <= '0;
      end else if (w_we_mcycle) begin
         r_mcycle[XLEN-1:0] <= w_new;
      end else if (w_we_mcycleh) begin
         r_mcycle[63:32] <= w_new[31:0];
      end else begin
         r_mcycle <= r_mcycle + 64'd1;
      end
   end

   // Redirect: one-cycle pulse after trap or mret; target holds between pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_redirect_valid <= trap_valid || mret_valid;
         if (trap_valid) begin
            r_redirect_pc <= f_trap_target(r_mtvec, trap_cause);
         end else if (mret_valid) begin
            r_redirect_pc <= r_mepc;
         end
      end
   end

   assign in_ready       = w_in_ready;
   assign out_valid      = r_vld_p1;
   assign out_rd_data    = r_rd_data_p1;
   assign out_illegal    = r_illegal_p1;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign mstatus_mie    = r_mie;

endmodule

// File: tb/tb_csr_regfile_ex.sv
// tb_csr_regfile_ex: scoreboard bench for csr_regfile_ex (XLEN=32).
// A behavioural CSR model predicts every result; a monitor compares results
// whenever the DUT presents one.
module tb_csr_regfile_ex;

   localparam int          XLEN      = 32;
   localparam logic [31:0] MTVEC_RST = 32'h0000_0040;
   localparam logic [31:0] HART      = 32'h0000_0003;

   localparam logic [2:0] RW  = 3'b001, RS  = 3'b010, RC  = 3'b011;
   localparam logic [2:0] RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_inst = '0;
   logic [31:0] in_rs1 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_rd_data;
   logic        out_illegal;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_cause = '0;
   logic [31:0] trap_pc = '0;
   logic [31:0] trap_val = '0;
   logic        mret_valid = 1'b0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mstatus_mie;

   always #5 clk = ~clk;

   csr_regfile_ex #(.XLEN(XLEN), .MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_rs1(in_rs1),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rd_data(out_rd_data), .out_illegal(out_illegal),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
      .mret_valid(mret_valid), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mstatus_mie(mstatus_mie)
   );

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct packed {
      logic [31:0] rd;
      logic        ill;
   } exp_t;
   exp_t sb_q[$];

   // Reference model state
   logic        m_mie, m_mpie, m_ov, m_rv;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
   logic [63:0] m_cyc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
      else n_pass++;
   endtask

   task automatic m_reset();
      m_mie = 0; m_mpie = 0; m_ov = 0; m_rv = 0;
      m_mtvec = MTVEC_RST & ~32'h2;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_rpc = 0;
      m_cyc = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a, output logic ok);
      ok = 1'b1;
      case (a)
         12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'hB00: return m_cyc[31:0];
         12'hB80: return m_cyc[63:32];
         12'hF14: return HART;
         default: begin ok = 1'b0; return 32'h0; end
      endcase
   endfunction

   task automatic m_write(input logic [11:0] a, input logic [31:0] v);
      case (a)
         12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
         12'h305: m_mtvec = v & ~32'h2;
         12'h340: m_mscratch = v;
         12'h341: m_mepc = v & ~32'h3;
         12'h342: m_mcause = v;
         12'h343: m_mtval = v;
         12'hB00: m_cyc[31:0] = v;
         12'hB80: m_cyc[63:32] = v;
         default: ;
      endcase
   endtask

   // One clock: check control outputs against the model, predict this edge, advance.
   task automatic step();
      logic        exp_ready, acc, ok, wants, ill, cyc_written;
      logic [2:0]  f3;
      logic [4:0]  z;
      logic [11:0] a;
      logic [31:0] src, old, nv;
      exp_t        e;
      @(negedge clk);
      exp_ready = (!m_ov || out_ready) && !trap_valid && !mret_valid;
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, m_ov);
      chk("mstatus_mie", mstatus_mie, m_mie);
      chk("redirect_valid", redirect_valid, m_rv);
      if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
      acc = in_valid && exp_ready;
      cyc_written = 1'b0;
      if (acc) begin
         f3  = in_inst[14:12];
         z   = in_inst[19:15];
         a   = in_inst[31:20];
         src = f3[2] ? {27'b0, z} : in_rs1;
         old = m_read(a, ok);
         wants = (f3[1:0] == 2'b01) || (z != 0);
         ill = !ok || (f3[1:0] == 2'b00) || (wants && a[11:10] == 2'b11);
         e.rd  = ill ? 32'h0 : old;
         e.ill = ill;
         sb_q.push_back(e);
         if (!ill && wants) begin
            case (f3[1:0])
               2'b01:   nv = src;
               2'b10:   nv = old | src;
               default: nv = old & ~src;
            endcase
            m_write(a, nv);
            cyc_written = (a == 12'hB00) || (a == 12'hB80);
         end
      end
      if (!cyc_written) m_cyc = m_cyc + 1;
      if (trap_valid) begin
         m_rpc = (m_mtvec & ~32'h3)
               + ((m_mtvec[0] && trap_cause[31]) ? 4 * (trap_cause & 32'h7FFF_FFFF) : 0);
         m_mepc = trap_pc & ~32'h3;
         m_mcause = trap_cause;
         m_mtval = trap_val;
         m_mpie = m_mie;
         m_mie = 1'b0;
         m_rv = 1'b1;
      end else if (mret_valid) begin
         m_rpc = m_mepc;
         m_mie = m_mpie;
         m_mpie = 1'b1;
         m_rv = 1'b1;
      end else begin
         m_rv = 1'b0;
      end
      if (acc) m_ov = 1'b1;
      else if (out_ready) m_ov = 1'b0;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [11:0] a,
                                           input logic [4:0] z);
      return {a, z, f3, 5'd1, 7'b1110011};
   endfunction

   task automatic op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] z,
                     input logic [31:0] v);
      in_inst = mk_inst(f3, a, z);
      in_rs1 = v;
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0; out_ready = 1'b1; trap_valid = 1'b0; mret_valid = 1'b0;
      repeat (n) step();
   endtask

   // Asynchronous reset, possibly in the middle of a held result.
   task automatic do_reset();
      rstn = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_rd_data", out_rd_data, 0);
      chk("rst_out_illegal", out_illegal, 0);
      chk("rst_redirect_valid", redirect_valid, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_mstatus_mie", mstatus_mie, 0);
      sb_q.delete();
      m_reset();
      in_valid = 1'b0; out_ready = 1'b1; trap_valid = 1'b0; mret_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Monitor: compare whenever a result is presented; retire it on handshake.
   always @(negedge clk) begin
      if (rstn === 1'b1 && out_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_result actual=%0h required=no_result", out_rd_data);
         end else begin
            chk("rd_data", out_rd_data, sb_q[0].rd);
            chk("illegal", out_illegal, sb_q[0].ill);
            if (out_ready) void'(sb_q.pop_front());
         end
      end
   end

   logic [11:0] addrs [11] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'hB00, 12'hB80, 12'hF14, 12'h7C0, 12'h301};

   initial begin
      rstn = 1'b1;
      m_reset();
      #2;
      do_reset();

      // Write/readback mtvec; reserved bit 1 reads zero.
      op(RW, 12'h305, 5'd1, 32'h8000_0103);
      chk("mtvec_old", out_rd_data, MTVEC_RST);
      op(RS, 12'h305, 5'd0, 32'h0);
      chk("mtvec_readback", out_rd_data, 32'h8000_0101);

      // mscratch set via zimm.
      op(RW, 12'h340, 5'd1, 32'h10);
      op(RSI, 12'h340, 5'd5, 32'h0);
      chk("mscratch_old", out_rd_data, 32'h10);
      op(RS, 12'h340, 5'd0, 32'h0);
      chk("mscratch_set", out_rd_data, 32'h15);

      // Read-only and unmapped accesses.
      op(RC, 12'hF14, 5'd0, 32'hFFFF_FFFF);
      chk("mhartid_read", out_rd_data, HART);
      chk("mhartid_read_ill", out_illegal, 0);
      op(RW, 12'hF14, 5'd1, 32'h55);
      chk("mhartid_write_ill", out_illegal, 1);
      chk("mhartid_write_rd", out_rd_data, 0);
      op(RS, 12'h7C0, 5'd0, 32'h0);
      chk("unmapped_ill", out_illegal, 1);
      op(3'b000, 12'h340, 5'd1, 32'h1);
      op(RCI, 12'hF14, 5'd0, 32'h0);
      idle(1);

      // Backpressure: hold the result, then stream back-to-back.
      in_inst = mk_inst(RS, 12'h340, 5'd0); in_rs1 = 0; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_inst = mk_inst(RS, 12'h305, 5'd0);
      repeat (3) begin
         step();
         chk("hold_rd_stable", out_rd_data, 32'h15);
      end
      out_ready = 1'b1;
      step();
      in_inst = mk_inst(RS, 12'h341, 5'd0);
      step();
      idle(2);

      // Vectored interrupt trap, then mret.
      op(RSI, 12'h300, 5'd8, 32'h0);
      op(RW, 12'h305, 5'd1, 32'h101);
      idle(1);
      trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h206; trap_val = 32'h55;
      step();
      trap_valid = 1'b0;
      chk("trap_redirect_valid", redirect_valid, 1);
      chk("trap_redirect_pc", redirect_pc, 32'h11C);
      chk("trap_mie", mstatus_mie, 0);
      op(RS, 12'h341, 5'd0, 32'h0);
      chk("trap_mepc", out_rd_data, 32'h204);
      op(RS, 12'h300, 5'd0, 32'h0);
      chk("trap_mstatus", out_rd_data, 32'h1880);
      mret_valid = 1'b1;
      step();
      mret_valid = 1'b0;
      chk("mret_redirect_pc", redirect_pc, 32'h204);
      chk("mret_mie", mstatus_mie, 1);
      idle(1);

      // Trap collides with a CSR op: op is dropped.
      in_inst = mk_inst(RW, 12'h340, 5'd1); in_rs1 = 32'hDEAD; in_valid = 1'b1;
      trap_valid = 1'b1; trap_cause = 32'h2; trap_pc = 32'h400;
      step();
      trap_valid = 1'b0; in_valid = 1'b0;
      op(RS, 12'h340, 5'd0, 32'h0);
      chk("trap_drop_mscratch", out_rd_data, 32'h15);

      // mcycle carry into mcycleh.
      op(RW, 12'hB00, 5'd1, 32'hFFFF_FFFF);
      op(RS, 12'hB00, 5'd0, 32'h0);
      chk("mcycle_written", out_rd_data, 32'hFFFF_FFFF);
      op(RS, 12'hB00, 5'd0, 32'h0);
      chk("mcycle_wrapped", out_rd_data, 32'h0);
      op(RS, 12'hB80, 5'd0, 32'h0);
      op(RW, 12'hB80, 5'd1, 32'h1234);
      op(RS, 12'hB80, 5'd0, 32'h0);
      chk("mcycleh_written", out_rd_data, 32'h1234);

      // Reset while a result is held.
      in_inst = mk_inst(RS, 12'h340, 5'd0); in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      do_reset();
      op(RS, 12'h305, 5'd0, 32'h0);
      chk("post_rst_mtvec", out_rd_data, MTVEC_RST);
      op(RS, 12'h340, 5'd0, 32'h0);
      op(RS, 12'h341, 5'd0, 32'h0);
      op(RS, 12'h300, 5'd0, 32'h0);
      idle(1);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         trap_valid = ($urandom_range(0, 24) == 0);
         mret_valid = ($urandom_range(0, 24) == 0);
         trap_cause = $urandom;
         trap_pc    = $urandom;
         trap_val   = $urandom;
         in_inst    = mk_inst(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 10)],
                              ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom));
         in_rs1     = $urandom;
         step();
      end

      // Drain remaining results within a bounded number of cycles.
      in_valid = 1'b0; out_ready = 1'b1; trap_valid = 1'b0; mret_valid = 1'b0;
      for (int i = 0; i < 8 && sb_q.size() != 0; i++) step();
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
